wb_bram_ctrl: RTL and testbench

Wishbone classic slave that acts as the initiator for the user-project BRAM port (byte-enable write, registered-address read). It decodes Caravel Wishbone accesses in the user address window, waits a programmable number of cycles to model slow external memory, then issues one BRAM write or read and returns a single-cycle ack with read data. It sits between the Wishbone interconnect and the BRAM instance holding the FIR tap/data memory.

---
 rtl/wb_bram_pkg.sv | 23 ++
 rtl/wb_bram_ctrl.sv | 141 ++++++++++++++
 tb/tb_wb_bram_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bram_pkg.sv
// Shared types and constants for the Wishbone-to-BRAM controller.
// Width defaults here are the Caravel user-project values.
package wb_bram_pkg;

    localparam int              WB_ADR_W    = 32;
    localparam int              WB_SEL_W    = 4;
    localparam int              WB_DAT_W    = 32;
    localparam int              BRAM_ADDR_W = 12;
    localparam logic [7:0]      BASE_HI_DEF = 8'h38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_READ,
        ST_ACK
    } state_e;

    function automatic int cnt_width(input int d);
        return (d < 1) ? 1 : $clog2(d + 1);
    endfunction

endpackage

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave driving a BRAM port: decode the user window, stall
// DELAY cycles, perform one BRAM write or registered read, then a one-cycle ack.
module wb_bram_ctrl
    import wb_bram_pkg::*;
#(
    parameter int         ADDR_WIDTH = BRAM_ADDR_W,
    parameter int         BIT_WIDTH  = WB_DAT_W,
    parameter int         DELAY      = 10,
    parameter logic [7:0] BASE_HI    = BASE_HI_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [WB_SEL_W-1:0]   wbs_sel_i,
    input  logic [WB_ADR_W-1:0]   wbs_adr_i,
    input  logic [BIT_WIDTH-1:0]  wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [BIT_WIDTH-1:0]  wbs_dat_o,
    output logic                  bram_en,
    output logic [WB_SEL_W-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_a,
    output logic [BIT_WIDTH-1:0]  bram_di,
    input  logic [BIT_WIDTH-1:0]  bram_do
);

    localparam int            CW       = cnt_width(DELAY);
    localparam logic [CW-1:0] DELAY_LD = CW'(DELAY);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [WB_SEL_W-1:0]   sel_q, sel_d;
    logic [BIT_WIDTH-1:0]  wdat_q, wdat_d;
    logic [BIT_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic [BIT_WIDTH-1:0]  dat_q, dat_d;
    logic                  hit;

    // Middle address bits only alias the window; they are intentionally dropped.
    logic unused_adr;
    assign unused_adr = ^wbs_adr_i[23:ADDR_WIDTH];

    assign hit = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:24] == BASE_HI);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    addr_d  = wbs_adr_i[ADDR_WIDTH-1:0];
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    wdat_d  = wbs_dat_i;
                    cnt_d   = DELAY_LD;
                    state_d = (DELAY == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Master may give up during the stall; nothing has touched BRAM yet.
                if (!(wbs_cyc_i && wbs_stb_i))
                    state_d = ST_IDLE;
                else if (cnt_q == CW'(1))
                    state_d = ST_ACCESS;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            ST_ACCESS: state_d = we_q ? ST_ACK : ST_READ;
            ST_READ: begin
                rdata_d = bram_do;
                state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ack_d = (state_d == ST_ACK);
        dat_d = (state_d == ST_ACK && !we_q) ? rdata_d : '0;
    end

    // BRAM side decodes from state and latched request only.
    always_comb begin
        bram_en = 1'b0;
        bram_we = '0;
        bram_a  = '0;
        bram_di = '0;
        case (state_q)
            ST_ACCESS: begin
                bram_en = 1'b1;
                bram_a  = addr_q;
                bram_di = wdat_q;
                bram_we = we_q ? sel_q : '0;
            end
            ST_READ: begin
                bram_en = 1'b1;
                bram_a  = addr_q;
            end
            default: ;
        endcase
        // Suppress the strobe in a reset cycle so no partial write lands.
        if (!RST_N) begin
            bram_en = 1'b0;
            bram_we = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: a DELAY=10 and a DELAY=0 instance, each with its own
// BRAM model, checked against a word-array reference memory and cycle rules.
module tb_wb_bram_ctrl;

    localparam int D0 = 10;
    localparam int D1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        dsel;

    logic        cyc0, cyc1;
    logic        ack0, ack1, en0, en1;
    logic [31:0] dato0, dato1, di0, di1, do0, do1;
    logic [3:0]  bwe0, bwe1;
    logic [11:0] a0, a1;

    assign cyc0 = cyc & ~dsel;
    assign cyc1 = cyc & dsel;

    wb_bram_ctrl #(.DELAY(D0)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .wbs_cyc_i(cyc0), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack0),
        .wbs_dat_o(dato0), .bram_en(en0), .bram_we(bwe0), .bram_a(a0),
        .bram_di(di0), .bram_do(do0));

    wb_bram_ctrl #(.DELAY(D1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .wbs_cyc_i(cyc1), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack1),
        .wbs_dat_o(dato1), .bram_en(en1), .bram_we(bwe1), .bram_a(a1),
        .bram_di(di1), .bram_do(do1));

    logic        ack_v, en_v;
    logic [31:0] dato_v, di_v;
    logic [3:0]  bwe_v;
    logic [11:0] a_v;
    assign ack_v  = dsel ? ack1  : ack0;
    assign en_v   = dsel ? en1   : en0;
    assign dato_v = dsel ? dato1 : dato0;
    assign di_v   = dsel ? di1   : di0;
    assign bwe_v  = dsel ? bwe1  : bwe0;
    assign a_v    = dsel ? a1    : a0;

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // BRAM models: byte-enable write, read-first registered read.
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    always @(posedge clk) begin
        if (en0) begin
            if (|bwe0) mem0[a0[11:2]] <= (mem0[a0[11:2]] & ~bmask(bwe0)) | (di0 & bmask(bwe0));
            do0 <= mem0[a0[11:2]];
        end
        if (en1) begin
            if (|bwe1) mem1[a1[11:2]] <= (mem1[a1[11:2]] & ~bmask(bwe1)) | (di1 & bmask(bwe1));
            do1 <= mem1[a1[11:2]];
        end
    end

    logic [31:0] ref_mem [2][1024];
    int errors = 0;
    int checks = 0;

    int          r_ack_cyc, r_acks, r_en_cnt, r_we_cnt, r_we_cyc, r_en_first;
    logic [3:0]  r_we_val;
    logic [11:0] r_a_we, r_a_en;
    logic [31:0] r_di_we, r_rd;

    // Drives one Wishbone transaction and records what the bus and BRAM port did.
    task automatic xfer(input logic d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd);
        r_ack_cyc = -1; r_acks = 0; r_en_cnt = 0; r_we_cnt = 0; r_we_cyc = -1;
        r_en_first = -1; r_we_val = 0; r_a_we = 0; r_a_en = 0; r_di_we = 0; r_rd = 0;
        @(posedge clk); #1;
        dsel = d; cyc = 1; stb = 1; we = w; adr = a; sel = s; dat = wd;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (en_v) begin
                r_en_cnt++;
                if (r_en_first < 0) begin r_en_first = c; r_a_en = a_v; end
            end
            if (bwe_v != 4'h0) begin
                r_we_cnt++;
                if (r_we_cyc < 0) begin r_we_cyc = c; r_we_val = bwe_v; r_a_we = a_v; r_di_we = di_v; end
            end
            if (ack_v) begin
                r_acks++;
                if (r_ack_cyc < 0) begin r_ack_cyc = c; r_rd = dato_v; end
            end
            @(posedge clk); #1;
            if (r_ack_cyc >= 0) begin cyc = 0; stb = 0; end
            if (r_ack_cyc >= 0 && c > r_ack_cyc) break;
        end
        cyc = 0; stb = 0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        return (o & ~bmask(s)) | (n & bmask(s));
    endfunction

    task automatic test_reset;
        rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0; dsel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({ack0, ack1, en0, en1} !== 4'b0) begin errors++; $display("FAIL rst_ctrl got=%b exp=0000", {ack0, ack1, en0, en1}); end
        checks++; if ({bwe0, bwe1, a0, a1} !== 32'h0) begin errors++; $display("FAIL rst_bram got=%h exp=0", {bwe0, bwe1, a0, a1}); end
        @(posedge clk); #1; rst_n = 1;
        @(negedge clk);
        checks++; if ({dato0, dato1, di0, di1} !== 128'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", {dato0, dato1, di0, di1}); end
        checks++; if ({ack0, en0, bwe0} !== 6'h0) begin errors++; $display("FAIL rst_idle got=%h exp=0", {ack0, en0, bwe0}); end
    endtask

    task automatic test_write_read;
        xfer(0, 1, 32'h3800_0008, 4'hF, 32'hDEAD_BEEF);
        ref_mem[0][2] = merge(ref_mem[0][2], 32'hDEAD_BEEF, 4'hF);
        checks++; if (r_we_cyc !== 11) begin errors++; $display("FAIL wr_strobe_cyc got=%0d exp=11", r_we_cyc); end
        checks++; if ({r_we_val, r_a_we} !== {4'hF, 12'h008}) begin errors++; $display("FAIL wr_strobe got=%h exp=f008", {r_we_val, r_a_we}); end
        checks++; if (r_di_we !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_di got=%h exp=deadbeef", r_di_we); end
        checks++; if ({r_ack_cyc, r_acks, r_we_cnt} !== {32'd12, 32'd1, 32'd1}) begin errors++; $display("FAIL wr_ack got cyc=%0d n=%0d we=%0d exp 12/1/1", r_ack_cyc, r_acks, r_we_cnt); end
        checks++; if (r_rd !== 32'h0) begin errors++; $display("FAIL wr_dat_o got=%h exp=0", r_rd); end

        xfer(0, 0, 32'h3800_0008, 4'hF, 32'h0);
        checks++; if (r_ack_cyc !== 13 || r_acks !== 1) begin errors++; $display("FAIL rd_ack got cyc=%0d n=%0d exp 13/1", r_ack_cyc, r_acks); end
        checks++; if (r_rd !== ref_mem[0][2]) begin errors++; $display("FAIL rd_data got=%h exp=%h", r_rd, ref_mem[0][2]); end
        checks++; if (r_we_cnt !== 0 || r_en_first !== 11 || r_en_cnt !== 2) begin errors++; $display("FAIL rd_bram got we=%0d en1st=%0d en=%0d exp 0/11/2", r_we_cnt, r_en_first, r_en_cnt); end

        xfer(0, 1, 32'h3800_0008, 4'b0010, 32'h0000_5500);
        ref_mem[0][2] = merge(ref_mem[0][2], 32'h0000_5500, 4'b0010);
        checks++; if (r_we_val !== 4'b0010) begin errors++; $display("FAIL byte_we got=%b exp=0010", r_we_val); end
        xfer(0, 0, 32'h3800_0008, 4'hF, 32'h0);
        checks++; if (r_rd !== 32'hDEAD_55EF || r_rd !== ref_mem[0][2]) begin errors++; $display("FAIL byte_rd got=%h exp=dead55ef", r_rd); end
    endtask

    task automatic test_abort;
        int en_n, ack_n;
        en_n = 0; ack_n = 0;
        @(posedge clk); #1;
        dsel = 0; cyc = 1; stb = 1; we = 1; adr = 32'h3800_0040; sel = 4'hF; dat = 32'h1111_2222;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (en_v) en_n++;
            if (ack_v) ack_n++;
            @(posedge clk); #1;
            if (c + 1 == 5) stb = 0;
        end
        cyc = 0; stb = 0;
        checks++; if (en_n !== 0 || ack_n !== 0) begin errors++; $display("FAIL abort got en=%0d ack=%0d exp 0/0", en_n, ack_n); end
        xfer(0, 0, 32'h3800_0040, 4'hF, 32'h0);
        checks++; if (r_ack_cyc !== 13 || r_rd !== ref_mem[0][16]) begin errors++; $display("FAIL after_abort got cyc=%0d rd=%h exp 13/%h", r_ack_cyc, r_rd, ref_mem[0][16]); end
    endtask

    task automatic test_miss_delay0;
        xfer(0, 1, 32'h3000_0000, 4'hF, 32'hFFFF_FFFF);
        checks++; if (r_acks !== 0 || r_en_cnt !== 0) begin errors++; $display("FAIL miss got ack=%0d en=%0d exp 0/0", r_acks, r_en_cnt); end
        xfer(0, 0, 32'h3000_0000, 4'hF, 32'h0);
        checks++; if (r_acks !== 0 || r_en_cnt !== 0) begin errors++; $display("FAIL miss_rd got ack=%0d en=%0d exp 0/0", r_acks, r_en_cnt); end

        xfer(1, 1, 32'h3800_0104, 4'hF, 32'hA5A5_0F0F);
        ref_mem[1][65] = merge(ref_mem[1][65], 32'hA5A5_0F0F, 4'hF);
        checks++; if (r_we_cyc !== 1 || r_ack_cyc !== 2 || r_acks !== 1) begin errors++; $display("FAIL d0_wr got we=%0d ack=%0d n=%0d exp 1/2/1", r_we_cyc, r_ack_cyc, r_acks); end
        xfer(1, 0, 32'h3800_0104, 4'hF, 32'h0);
        checks++; if (r_ack_cyc !== 3 || r_rd !== ref_mem[1][65]) begin errors++; $display("FAIL d0_rd got cyc=%0d rd=%h exp 3/%h", r_ack_cyc, r_rd, ref_mem[1][65]); end
    endtask

    task automatic test_reset_access;
        int ack_n;
        ack_n = 0;
        xfer(0, 1, 32'h3800_0010, 4'hF, 32'h1234_5678);
        ref_mem[0][4] = 32'h1234_5678;
        @(posedge clk); #1;
        dsel = 0; cyc = 1; stb = 1; we = 1; adr = 32'h3800_0010; sel = 4'hF; dat = 32'hCAFE_F00D;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (ack_v) ack_n++;
            if (c == 11) begin
                checks++; if (bwe_v !== 4'h0 || en_v !== 1'b0) begin errors++; $display("FAIL rst_access got we=%h en=%b exp 0/0", bwe_v, en_v); end
            end
            if (c == 12) begin
                checks++; if (ack_v !== 1'b0 || en_v !== 1'b0) begin errors++; $display("FAIL post_rst got ack=%b en=%b exp 0/0", ack_v, en_v); end
            end
            @(posedge clk); #1;
            if (c + 1 == 11) begin rst_n = 0; cyc = 0; stb = 0; end
            if (c == 11) rst_n = 1;
        end
        checks++; if (ack_n !== 0) begin errors++; $display("FAIL rst_no_ack got=%0d exp=0", ack_n); end
        xfer(0, 0, 32'h3800_0010, 4'hF, 32'h0);
        checks++; if (r_rd !== ref_mem[0][4]) begin errors++; $display("FAIL rst_mem got=%h exp=%h", r_rd, ref_mem[0][4]); end
    endtask

    task automatic test_random;
        logic        d, w;
        logic [31:0] a, wd;
        logic [3:0]  s;
        int          dly, exp_ack;
        for (int i = 0; i < 40; i++) begin
            d  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            a  = {8'h38, 24'($urandom)};
            a[11:2] = 10'($urandom_range(0, 15));
            s  = 4'($urandom_range(1, 15));
            wd = $urandom;
            dly = d ? D1 : D0;
            exp_ack = w ? dly + 2 : dly + 3;
            xfer(d, w, a, s, wd);
            checks++; if (r_ack_cyc !== exp_ack || r_acks !== 1) begin errors++; $display("FAIL rnd%0d_ack got cyc=%0d n=%0d exp %0d/1", i, r_ack_cyc, r_acks, exp_ack); end
            if (w) begin
                ref_mem[d][a[11:2]] = merge(ref_mem[d][a[11:2]], wd, s);
                checks++; if ({r_we_val, r_a_we, r_di_we} !== {s, a[11:0], wd}) begin errors++; $display("FAIL rnd%0d_wr got %h exp %h", i, {r_we_val, r_a_we, r_di_we}, {s, a[11:0], wd}); end
            end else begin
                checks++; if (r_rd !== ref_mem[d][a[11:2]] || r_a_en !== a[11:0]) begin errors++; $display("FAIL rnd%0d_rd got %h@%h exp %h@%h", i, r_rd, r_a_en, ref_mem[d][a[11:2]], a[11:0]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 32'h0; mem1[i] = 32'h0;
            ref_mem[0][i] = 32'h0; ref_mem[1][i] = 32'h0;
        end
        test_reset;
        test_write_read;
        test_abort;
        test_miss_delay0;
        test_reset_access;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
